// File: rtl/mimo_symbol_mapper_pkg.sv
// Shared encodings for the MIMO QPSK symbol mapper: index codes, coordinate width, FSM states.
package mimo_symbol_mapper_pkg;

   localparam int COORD_W = 56;

   typedef logic signed [COORD_W-1:0] coord_t;

   // Constellation index encodings, matching the receive-side slicer decisions.
   localparam logic [1:0] IDX_POS_RE = 2'd0;
   localparam logic [1:0] IDX_POS_IM = 2'd1;
   localparam logic [1:0] IDX_NEG_IM = 2'd2;
   localparam logic [1:0] IDX_NEG_RE = 2'd3;

   // FSM state encoding.
   localparam logic [0:0] ST_COLLECT = 1'b0;
   localparam logic [0:0] ST_FULL    = 1'b1;

endpackage

// File: rtl/mimo_symbol_mapper_qpsk_point_lut.sv
// Combinational QPSK point lookup: 2-bit constellation index -> signed (real, imag).
module qpsk_point_lut
   import mimo_symbol_mapper_pkg::*;
#(
   parameter coord_t AMP = 56'sd1024
) (
   input  logic [1:0] idx,
   output coord_t     re,
   output coord_t     im
);

   // Map index to its constellation point; negative axes are two's-complement of AMP.
   always_comb begin
      re = '0;
      im = '0;
      case (idx)
         IDX_POS_RE: re = AMP;
         IDX_POS_IM: im = AMP;
         IDX_NEG_IM: im = -AMP;
         IDX_NEG_RE: re = -AMP;
         default: ;
      endcase
   end

endmodule

// File: rtl/mimo_symbol_mapper.sv
// Two-antenna QPSK mapper: collects 4 serial bits, emits one registered symbol vector.
module mimo_symbol_mapper
   import mimo_symbol_mapper_pkg::*;
#(
   parameter coord_t      AMP       = 56'sd1024,
   parameter int unsigned FRAME_LEN = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         bit_in,
   input  logic         bit_valid,
   output logic         bit_ready,
   output coord_t       x_real_1,
   output coord_t       x_imag_1,
   output coord_t       x_real_2,
   output coord_t       x_imag_2,
   output logic [1:0]   sym_idx_1,
   output logic [1:0]   sym_idx_2,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_last
);

   localparam logic [7:0] LAST_CNT = 8'(FRAME_LEN - 1);

   logic [0:0] state;
   logic [1:0] bit_cnt;
   logic [2:0] bits;       // first three bits of the vector, oldest in the MSB
   logic [7:0] frame_cnt;

   logic       bit_fire;
   logic       out_fire;
   logic [3:0] word;
   logic [1:0] nxt_idx_1;
   logic [1:0] nxt_idx_2;
   coord_t     lut_re_1, lut_im_1, lut_re_2, lut_im_2;

   // Handshake decode and the vector formed when the 4th bit arrives.
   always_comb begin
      bit_ready = (state == ST_COLLECT);
      out_valid = (state == ST_FULL);
      out_last  = out_valid && (frame_cnt == LAST_CNT);
      bit_fire  = bit_valid && bit_ready;
      out_fire  = out_valid && out_ready;
      word      = {bits, bit_in};
      nxt_idx_1 = word[3:2];
      nxt_idx_2 = word[1:0];
   end

   qpsk_point_lut #(.AMP(AMP)) u_lut_1 (
      .idx (nxt_idx_1),
      .re  (lut_re_1),
      .im  (lut_im_1)
   );

   qpsk_point_lut #(.AMP(AMP)) u_lut_2 (
      .idx (nxt_idx_2),
      .re  (lut_re_2),
      .im  (lut_im_2)
   );

   // FSM, bit collector, frame counter and registered output vector.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_COLLECT;
         bit_cnt   <= 2'd0;
         bits      <= 3'd0;
         frame_cnt <= 8'd0;
         x_real_1  <= '0;
         x_imag_1  <= '0;
         x_real_2  <= '0;
         x_imag_2  <= '0;
         sym_idx_1 <= 2'd0;
         sym_idx_2 <= 2'd0;
      end else begin
         case (state)
            ST_COLLECT: begin
               if (bit_fire) begin
                  bits    <= {bits[1:0], bit_in};
                  bit_cnt <= bit_cnt + 2'd1;  // wraps to 0 on the 4th bit
                  if (bit_cnt == 2'd3) begin
                     state     <= ST_FULL;
                     x_real_1  <= lut_re_1;
                     x_imag_1  <= lut_im_1;
                     x_real_2  <= lut_re_2;
                     x_imag_2  <= lut_im_2;
                     sym_idx_1 <= nxt_idx_1;
                     sym_idx_2 <= nxt_idx_2;
                  end
               end
            end
            default: begin
               if (out_fire) begin
                  state     <= ST_COLLECT;
                  frame_cnt <= (frame_cnt == LAST_CNT) ? 8'd0 : frame_cnt + 8'd1;
               end
            end
         endcase
      end
   end

endmodule
